// File: rtl/cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cmd_sequencer_if
// Purpose  : Bundles the command-push, controller and result signals of
//            cmd_sequencer.
//            master : command producer / controller model (drives cmd_in,
//                     cmd_valid, flush, O/C/Z/N, y)
//            slave  : the sequencer (drives cmd_ready, command, syscall,
//                     res_valid, res_y, res_flags, res_retries, busy, level)
//            level is $clog2(DEPTH)+1 bits; DEPTH must match the sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface cmd_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int c_LW = $clog2(DEPTH) + 1;

    // command push side
    logic [11:0]     cmd_in;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            flush;
    // downstream controller
    logic [11:0]     command;
    logic            syscall;
    logic            O;
    logic            C;
    logic            Z;
    logic            N;
    logic [31:0]     y;
    // result / status
    logic            res_valid;
    logic [31:0]     res_y;
    logic [3:0]      res_flags;
    logic [2:0]      res_retries;
    logic            busy;
    logic [c_LW-1:0] level;

    modport master (
        output cmd_in, cmd_valid, flush, O, C, Z, N, y,
        input  cmd_ready, command, syscall, res_valid, res_y, res_flags,
               res_retries, busy, level
    );

    modport slave (
        input  cmd_in, cmd_valid, flush, O, C, Z, N, y,
        output cmd_ready, command, syscall, res_valid, res_y, res_flags,
               res_retries, busy, level
    );
endinterface
`default_nettype wire

// File: rtl/cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cmd_sequencer
// Purpose  : Queues 12-bit commands in a FIFO and issues them one at a time
//            to a downstream controller: pop -> one-cycle syscall strobe ->
//            SETTLE wait cycles -> capture of y and {O,C,Z,N} with a
//            one-cycle res_valid pulse.
// Ports    : clk    - single clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - cmd_sequencer_if.slave (push handshake, flush, command,
//                     syscall, flags/y from controller, result and status)
// Options  : CMD_SEQ_CAS_RETRY_EN - when defined, a CAS command (opcode
//            3'b111) that returns y==0 is re-issued up to MAX_RETRY times.
//            Undefined (default): no re-issue, res_retries tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module cmd_sequencer #(
    parameter int DEPTH     = 8,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    cmd_sequencer_if.slave     bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_WAIT    = 2'd2;
    localparam logic [1:0] c_CAPTURE = 2'd3;

    // Elaboration-time parameter range checks.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("cmd_sequencer: DEPTH must be a power of two >= 2");
        end
        if (SETTLE < 1) begin : g_bad_settle
            $error("cmd_sequencer: SETTLE must be >= 1");
        end
        if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_retry
            $error("cmd_sequencer: MAX_RETRY must be in 1..7");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [11:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_wait_cnt;
    logic [11:0]     r_command;
    logic            r_res_valid;
    logic [31:0]     r_res_y;
    logic [3:0]      r_res_flags;

    logic            w_full;
    logic            w_push;
    logic            w_retry;
    logic            w_done;
    logic            w_pop;

    assign w_full = (r_level == c_LW'(DEPTH));
    assign w_push = bus.cmd_valid && !w_full;

    // A finished capture with work queued pops straight into ISSUE so that
    // consecutive syscall strobes are SETTLE+2 cycles apart.
    assign w_done = (r_state == c_CAPTURE) && !w_retry;
    assign w_pop  = (r_level != '0) && ((r_state == c_IDLE) || w_done);

    // ------------------------------------------------------------------------
    // Optional CAS re-issue
    // ------------------------------------------------------------------------
`ifdef CMD_SEQ_CAS_RETRY_EN
    logic [2:0] r_retry;
    logic [2:0] r_res_retries;

    assign w_retry = (r_state == c_CAPTURE) &&
                     (r_command[11:9] == 3'b111) &&
                     (bus.y == 32'd0) &&
                     (r_retry < 3'(MAX_RETRY));

    // The count restarts on every pop; the value used by a finishing command
    // is copied out on the same edge the pop may clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry       <= 3'd0;
            r_res_retries <= 3'd0;
        end else begin
            if (w_done) begin
                r_res_retries <= r_retry;
            end
            if (w_pop) begin
                r_retry <= 3'd0;
            end else if (w_retry) begin
                r_retry <= r_retry + 3'd1;
            end
        end
    end

    assign bus.res_retries = r_res_retries;
`else
    assign w_retry         = 1'b0;
    assign bus.res_retries = 3'd0;
`endif

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy; flush overrides a same-cycle push
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Entry storage needs no reset: only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (w_push && !bus.flush) begin
            r_mem[r_wr_ptr] <= bus.cmd_in;
        end
    end

    // ------------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_wait_cnt  <= '0;
            r_command   <= 12'd0;
            r_res_valid <= 1'b0;
            r_res_y     <= 32'd0;
            r_res_flags <= 4'd0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_command <= r_mem[r_rd_ptr];
                        r_state   <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= c_WAIT;
                end
                c_WAIT: begin
                    if (r_wait_cnt == c_CW'(SETTLE - 1)) begin
                        r_state <= c_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_CW'(1);
                    end
                end
                c_CAPTURE: begin
                    if (w_retry) begin
                        // same command re-issued, no result reported
                        r_state <= c_ISSUE;
                    end else begin
                        r_res_valid <= 1'b1;
                        r_res_y     <= bus.y;
                        r_res_flags <= {bus.O, bus.C, bus.Z, bus.N};
                        if (w_pop) begin
                            r_command <= r_mem[r_rd_ptr];
                            r_state   <= c_ISSUE;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.cmd_ready = !w_full;
    assign bus.command   = r_command;
    assign bus.syscall   = (r_state == c_ISSUE);
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.level     = r_level;
    assign bus.res_valid = r_res_valid;
    assign bus.res_y     = r_res_y;
    assign bus.res_flags = r_res_flags;

endmodule
`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_sequencer
// Purpose  : Directed self-checking bench for cmd_sequencer (DEPTH=8,
//            SETTLE=2, MAX_RETRY=3). The CAS re-issue scenario follows
//            CMD_SEQ_CAS_RETRY_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_cmd_sequencer;

    localparam int DEPTH     = 8;
    localparam int SETTLE    = 2;
    localparam int MAX_RETRY = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

    cmd_sequencer #(
        .DEPTH     (DEPTH),
        .SETTLE    (SETTLE),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    // controller model: y is a constant unless y_mode==1, in which case it
    // returns 0 for the first two strobes since sys_base and 1 afterwards
    logic [1:0]  y_mode    = 2'd0;
    logic [31:0] y_val     = 32'd0;
    logic [3:0]  flags_val = 4'd0;
    int          sys_base  = 0;

    int          cyc   = 0;
    int          n_sys = 0;
    int          n_res = 0;
    int          res_cyc = 0;
    logic [11:0] sys_q[$];
    int          sys_cyc_q[$];

    assign bus.y = (y_mode == 2'd1) ? (((n_sys - sys_base) >= 3) ? 32'd1 : 32'd0)
                                    : y_val;
    assign {bus.O, bus.C, bus.Z, bus.N} = flags_val;

    // event monitor, sampled shortly after each rising edge
    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (bus.syscall === 1'b1) begin
            n_sys++;
            sys_q.push_back(bus.command);
            sys_cyc_q.push_back(cyc);
        end
        if (bus.res_valid === 1'b1) begin
            n_res++;
            res_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // caller sits at a falling edge; the push lands on the next rising edge
    task automatic push(input logic [11:0] c);
        bus.cmd_in    = c;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input int target, input int max_cyc);
        int k = 0;
        while (n_res < target && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check_val("res_wait", 32'(n_res), 32'(target));
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while ((bus.busy !== 1'b0 || bus.level !== '0) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check_val("idle_wait", {30'd0, bus.busy, (bus.level != '0)}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int r0;
        int acc;
        int errs;

        bus.cmd_in    = 12'd0;
        bus.cmd_valid = 1'b0;
        bus.flush     = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_val("rst_syscall",   32'(bus.syscall),     32'd0);
        check_val("rst_command",   32'(bus.command),     32'd0);
        check_val("rst_res_valid", 32'(bus.res_valid),   32'd0);
        check_val("rst_res_y",     bus.res_y,            32'd0);
        check_val("rst_res_flags", 32'(bus.res_flags),   32'd0);
        check_val("rst_retries",   32'(bus.res_retries), 32'd0);
        check_val("rst_busy",      32'(bus.busy),        32'd0);
        check_val("rst_level",     32'(bus.level),       32'd0);
        check_val("rst_ready",     32'(bus.cmd_ready),   32'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("empty_no_pop", 32'(n_sys), 32'd0);

        // ---------------- single command, latency ----------------
        y_val = 32'd5; flags_val = 4'b0000;
        s0 = n_sys; r0 = n_res;
        push(12'h0D1);
        check_val("push_level", 32'(bus.level), 32'd1);
        wait_res(r0 + 1, 20);
        check_val("one_pulses",   32'(n_sys - s0),                    32'd1);
        check_val("one_cmd",      32'(sys_q[s0]),                     32'h0D1);
        check_val("one_latency",  32'(res_cyc - sys_cyc_q[s0]),       32'(SETTLE + 2));
        check_val("one_res_y",    bus.res_y,                          32'd5);
        check_val("one_flags",    32'(bus.res_flags),                 32'd0);
        check_val("one_retries",  32'(bus.res_retries),               32'd0);
        @(negedge clk);
        check_val("one_pulse_w",  32'(bus.res_valid),                 32'd0);
        check_val("one_hold_y",   bus.res_y,                          32'd5);

        // ---------------- three back-to-back ----------------
        y_val = 32'hDEADBEEF; flags_val = 4'b1011;
        s0 = n_sys; r0 = n_res;
        push(12'h011);
        push(12'h022);
        push(12'h033);
        wait_res(r0 + 3, 40);
        check_val("b2b_pulses", 32'(n_sys - s0),                      32'd3);
        check_val("b2b_cmd0",   32'(sys_q[s0]),                       32'h011);
        check_val("b2b_cmd1",   32'(sys_q[s0 + 1]),                   32'h022);
        check_val("b2b_cmd2",   32'(sys_q[s0 + 2]),                   32'h033);
        check_val("b2b_gap01",  32'(sys_cyc_q[s0 + 1] - sys_cyc_q[s0]),     32'(SETTLE + 2));
        check_val("b2b_gap12",  32'(sys_cyc_q[s0 + 2] - sys_cyc_q[s0 + 1]), 32'(SETTLE + 2));
        check_val("b2b_res_y",  bus.res_y,                            32'hDEADBEEF);
        check_val("b2b_flags",  32'(bus.res_flags),                   32'hB);
        wait_idle(40);

        // ---------------- fill to full, drop when full ----------------
        // Pushing every cycle against one pop per SETTLE+2 cycles, the
        // FIFO becomes full after the 11th accepted push.
        y_val = 32'd1; flags_val = 4'b0000;
        s0 = n_sys; r0 = n_res; acc = 0;
        while (bus.cmd_ready === 1'b1 && acc < 64) begin
            push(12'(12'h100 + acc));
            acc++;
        end
        check_val("full_accepted", 32'(acc),           32'd11);
        check_val("full_ready",    32'(bus.cmd_ready), 32'd0);
        check_val("full_level",    32'(bus.level),     32'(DEPTH));
        push(12'hABC);
        check_val("drop_level",    32'(bus.level),     32'(DEPTH));
        wait_idle(200);
        check_val("full_pulses",   32'(n_sys - s0),    32'(acc));
        check_val("full_results",  32'(n_res - r0),    32'(acc));
        errs = 0;
        for (int i = 0; i < acc; i++) begin
            if (sys_q[s0 + i] !== 12'(12'h100 + i)) errs++;
        end
        check_val("full_order", 32'(errs), 32'd0);
        errs = 0;
        for (int i = s0; i < sys_q.size(); i++) begin
            if (sys_q[i] === 12'hABC) errs++;
        end
        check_val("drop_absent", 32'(errs), 32'd0);

        // ---------------- CAS command ----------------
`ifdef CMD_SEQ_CAS_RETRY_EN
        y_mode = 2'd1; sys_base = n_sys;
        s0 = n_sys; r0 = n_res;
        push(12'hE53);
        wait_idle(60);
        check_val("cas_pulses",  32'(n_sys - s0),        32'd3);
        check_val("cas_results", 32'(n_res - r0),        32'd1);
        check_val("cas_res_y",   bus.res_y,              32'd1);
        check_val("cas_retries", 32'(bus.res_retries),   32'd2);
        y_mode = 2'd0; y_val = 32'd0;
        s0 = n_sys; r0 = n_res;
        push(12'hE53);
        wait_idle(60);
        check_val("cas0_pulses",  32'(n_sys - s0),       32'(MAX_RETRY + 1));
        check_val("cas0_results", 32'(n_res - r0),       32'd1);
        check_val("cas0_res_y",   bus.res_y,             32'd0);
        check_val("cas0_retries", 32'(bus.res_retries),  32'(MAX_RETRY));
`else
        y_mode = 2'd0; y_val = 32'd0;
        s0 = n_sys; r0 = n_res;
        push(12'hE53);
        wait_idle(60);
        check_val("cas_pulses",  32'(n_sys - s0),        32'd1);
        check_val("cas_results", 32'(n_res - r0),        32'd1);
        check_val("cas_res_y",   bus.res_y,              32'd0);
        check_val("cas_retries", 32'(bus.res_retries),   32'd0);
`endif

        // ---------------- flush with same-cycle push ----------------
        y_val = 32'd7; flags_val = 4'b0100;
        s0 = n_sys; r0 = n_res;
        for (int i = 1; i <= 6; i++) begin
            push(12'(12'h200 + i));
        end
        check_val("fl_level_pre", 32'(bus.level), 32'd4);
        bus.flush = 1'b1;
        push(12'h3AA);
        bus.flush = 1'b0;
        check_val("fl_level",     32'(bus.level),     32'd0);
        check_val("fl_ready",     32'(bus.cmd_ready), 32'd1);
        wait_idle(50);
        check_val("fl_pulses",    32'(n_sys - s0),    32'd2);
        check_val("fl_inflight",  32'(sys_q[s0 + 1]), 32'h202);
        check_val("fl_results",   32'(n_res - r0),    32'd2);
        check_val("fl_res_y",     bus.res_y,          32'd7);
        check_val("fl_flags",     32'(bus.res_flags), 32'h4);

        // ---------------- reset during WAIT ----------------
        y_val = 32'd9; flags_val = 4'b0000;
        s0 = n_sys; r0 = n_res;
        push(12'h301);
        push(12'h302);
        push(12'h303);
        check_val("mr_busy_pre",  32'(bus.busy),  32'd1);
        check_val("mr_level_pre", 32'(bus.level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mr_syscall",   32'(bus.syscall),   32'd0);
        check_val("mr_busy",      32'(bus.busy),      32'd0);
        check_val("mr_level",     32'(bus.level),     32'd0);
        check_val("mr_command",   32'(bus.command),   32'd0);
        check_val("mr_res_y",     bus.res_y,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_val("mr_no_result", 32'(n_res - r0),    32'd0);
        check_val("mr_no_issue",  32'(n_sys - s0),    32'd1);
        check_val("mr_idle",      32'(bus.busy),      32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameter: DEPTH, 8, command FIFO entries (power of 2, >=2).
REQ-002 Parameter: SETTLE, 2, cycles the command is held after the syscall pulse before results are sampled (>=1).
REQ-003 Parameter: MAX_RETRY, 3, maximum CAS re-issues per command (1..7).
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: cmd_in  in  12  command to enqueue: [11:9] opcode, [8:6] addr1, [5:3] addr2, [2:0] addr3.
REQ-007 Port: cmd_valid  in  1  push request for cmd_in.
REQ-008 Port: cmd_ready  out  1  high when the FIFO is not full.
REQ-009 Port: flush  in  1  synchronous FIFO clear.
REQ-010 Port: command  out  12  command driven to the downstream controller.
REQ-011 Port: syscall  out  1  one-cycle run strobe to the controller.
REQ-012 Port: O, C, Z, N  in  1 each  ALU flags returned by the controller.
REQ-013 Port: y  in  32  result returned by the controller.
REQ-014 Port: res_valid  out  1  one-cycle pulse; result fields valid.
REQ-015 Port: res_y  out  32  captured y.
REQ-016 Port: res_flags  out  4  captured {O,C,Z,N}.
REQ-017 Port: res_retries  out  3  CAS re-issues used for this result.
REQ-018 Port: busy  out  1  high in any state other than IDLE.
REQ-019 Port: level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-020 Push occurs when cmd_valid && cmd_ready; the entry is visible (level incremented) on the next cycle.
REQ-021 Push while full is dropped; FIFO contents and level are unchanged.
REQ-022 Simultaneous push and pop leave level unchanged; read and write pointers wrap modulo DEPTH.
REQ-023 FSM states: IDLE, ISSUE, WAIT, CAPTURE.
REQ-024 IDLE with level>0: pop the head into command and go to ISSUE; IDLE with level==0: remain in IDLE, command holds its last value.
REQ-025 ISSUE lasts 1 cycle with syscall=1, then goes to WAIT; syscall is 0 in every other state.
REQ-026 WAIT lasts exactly SETTLE cycles, then goes to CAPTURE; command is stable from ISSUE through CAPTURE.
REQ-027 On the edge leaving CAPTURE, the block latches y into res_y and {O,C,Z,N} into res_flags, and asserts res_valid for one cycle, returning to IDLE.
REQ-028 Latency: if syscall rises at edge E, res_valid rises at edge E+SETTLE+2.
REQ-029 The next pop may occur in the cycle res_valid is high (back-to-back issue).
REQ-030 flush empties the FIFO and sets level to 0 next cycle; it does not abort the in-flight command; flush wins over a same-cycle push.
REQ-031 res_y, res_flags and res_retries hold their values until the next capture.

Reset
REQ-032 While rst_n=0, the block forces, asynchronously:
  - state to IDLE
  - syscall=0, command=0, res_valid=0, res_y=0, res_flags=0, res_retries=0, busy=0
  - level=0 and both FIFO pointers to 0
REQ-033 Reset mid-operation discards the in-flight command and all queued entries; no res_valid is produced for them.
REQ-034 After rst_n rises, the first pop occurs no earlier than the first rising edge with level>0.

Configuration
REQ-035 Macro CMD_SEQ_CAS_RETRY_EN defined: in CAPTURE, if command[11:9]==3'b111 and y==0 and the retry count is below MAX_RETRY, the FSM goes to ISSUE instead of IDLE, increments the retry count and suppresses res_valid. Otherwise the result is captured normally with res_retries equal to the retry count. The count clears on each new pop.
REQ-036 Macro CMD_SEQ_CAS_RETRY_EN undefined: no re-issue; every command produces exactly one res_valid; res_retries is tied to 0.

Verification
REQ-037 Reset, SETTLE=2; push 12'h0D1; controller returns y=5, flags=4'b0000 -> syscall pulse at edge E, res_valid at E+4, res_y=5, res_flags=0.
REQ-038 DEPTH=8, downstream stalled by continuous busy; push 9 commands -> cmd_ready low after the 8th push, 9th dropped, level=8.
REQ-039 Push 3 commands back-to-back -> 3 syscall pulses spaced SETTLE+2 cycles apart, in push order.
REQ-040 CMD_SEQ_CAS_RETRY_EN defined; push CAS 12'hE53; y=0 on the first two captures, then y=1 -> 3 syscall pulses, 1 res_valid, res_y=1, res_retries=2. Repeat with y always 0 and MAX_RETRY=3 -> 4 pulses, res_y=0, res_retries=3.
REQ-041 Assert rst_n=0 during WAIT with 2 commands queued -> syscall=0, busy=0, level=0 immediately; no res_valid after release.
REQ-042 flush and a push in the same cycle with 4 entries queued -> level=0 next cycle; the in-flight result still delivered.
